// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
// State encoding and the per-stage control bundle live here.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_t;

    localparam int unsigned DRAIN_CYCLES_DEF = 3;

    typedef struct packed {
        logic pc_we;
        logic ifid_we;
        logic ifid_flush;
        logic idex_we;
        logic idex_flush;
        logic exmem_we;
        logic memwb_we;
    } ctrl_t;

    localparam ctrl_t CTRL_RUN = 7'b11_0_1_0_11;
    localparam ctrl_t CTRL_RST = 7'b00_1_0_1_00;
    localparam ctrl_t CTRL_OFF = 7'b00_0_0_0_00;

endpackage

// File: rtl/hazard_detect.sv
// Load-use comparator: the ID instruction reads the register
// the load currently in EX is about to write.
module hazard_detect (
    input  logic [2:0] r1Num_id,
    input  logic [2:0] r2Num_id,
    input  logic       r1Used_id,
    input  logic       r2Used_id,
    input  logic [2:0] regWriteNum_ex,
    input  logic       regWriteEnable_ex,
    input  logic       memReadEnable_ex,
    output logic       lu
);

    logic hit1;
    logic hit2;

    assign hit1 = r1Used_id && (r1Num_id == regWriteNum_ex);
    assign hit2 = r2Used_id && (r2Num_id == regWriteNum_ex);
    assign lu   = memReadEnable_ex && regWriteEnable_ex && (hit1 || hit2);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the five-stage pipeline, with halt
// drain and a saturating stall-cycle counter.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned DRAIN_CYCLES = DRAIN_CYCLES_DEF,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       r1Num_id,
    input  logic [2:0]       r2Num_id,
    input  logic             r1Used_id,
    input  logic             r2Used_id,
    input  logic             halt_id,
    input  logic [2:0]       regWriteNum_ex,
    input  logic             regWriteEnable_ex,
    input  logic             memReadEnable_ex,
    input  logic             redirect_ex,
    input  logic             imem_busy,
    input  logic             dmem_busy,
    input  logic             stall_cnt_clr,
    output logic             pc_we,
    output logic             ifid_we,
    output logic             ifid_flush,
    output logic             idex_we,
    output logic             idex_flush,
    output logic             exmem_we,
    output logic             memwb_we,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [2:0] DRAIN_INIT = 3'(DRAIN_CYCLES);

    state_t           state_q;
    state_t           state_d;
    logic [2:0]       drain_q;
    logic [2:0]       drain_d;
    logic [CNT_W-1:0] stall_q;
    logic             lu;
    logic             stall_inc;
    ctrl_t            ctrl;

    hazard_detect u_hazard_detect (
        .r1Num_id          (r1Num_id),
        .r2Num_id          (r2Num_id),
        .r1Used_id         (r1Used_id),
        .r2Used_id         (r2Used_id),
        .regWriteNum_ex    (regWriteNum_ex),
        .regWriteEnable_ex (regWriteEnable_ex),
        .memReadEnable_ex  (memReadEnable_ex),
        .lu                (lu)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= RUN;
            drain_q <= 3'd0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
        end
    end

    always_comb begin
        state_d = state_q;
        drain_d = drain_q;
        unique case (state_q)
            RUN: begin
                if (!dmem_busy && !redirect_ex && !lu && halt_id) begin
                    state_d = DRAIN;
                    drain_d = DRAIN_INIT;
                end
            end
            DRAIN: begin
                if (!dmem_busy) begin
                    drain_d = drain_q - 3'd1;
                    if (drain_q == 3'd1)
                        state_d = HALTED;
                end
            end
            HALTED: ;
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        ctrl      = CTRL_RUN;
        halted    = 1'b0;
        stall_inc = 1'b0;
        if (!rst) begin
            ctrl = CTRL_RST;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (dmem_busy) begin
                        ctrl      = CTRL_OFF;
                        stall_inc = 1'b1;
                    end else if (redirect_ex) begin
                        ctrl.ifid_flush = 1'b1;
                        ctrl.idex_flush = 1'b1;
                    end else if (lu) begin
                        ctrl.pc_we      = 1'b0;
                        ctrl.ifid_we    = 1'b0;
                        ctrl.idex_flush = 1'b1;
                        stall_inc       = 1'b1;
                    end else if (halt_id) begin
                        ctrl.pc_we      = 1'b0;
                        ctrl.ifid_flush = 1'b1;
                    end else if (imem_busy) begin
                        ctrl.pc_we      = 1'b0;
                        ctrl.ifid_flush = 1'b1;
                        stall_inc       = 1'b1;
                    end
                end
                DRAIN: begin
                    ctrl.pc_we      = 1'b0;
                    ctrl.ifid_flush = 1'b1;
                    ctrl.idex_flush = 1'b1;
                    ctrl.exmem_we   = !dmem_busy;
                    ctrl.memwb_we   = !dmem_busy;
                end
                HALTED: begin
                    ctrl   = CTRL_OFF;
                    halted = 1'b1;
                end
                default: ctrl = CTRL_OFF;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            stall_q <= '0;
        else if (stall_cnt_clr)
            stall_q <= '0;
        else if (stall_inc && !(&stall_q))
            stall_q <= stall_q + CNT_W'(1);
    end

    assign pc_we      = ctrl.pc_we;
    assign ifid_we    = ctrl.ifid_we;
    assign ifid_flush = ctrl.ifid_flush;
    assign idex_we    = ctrl.idex_we;
    assign idex_flush = ctrl.idex_flush;
    assign exmem_we   = ctrl.exmem_we;
    assign memwb_we   = ctrl.memwb_we;
    assign stall_cnt  = stall_q;

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central stall/flush sequencer for the five-stage pipeline. It drives the write-enable and flush (bubble-insert) controls of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers. It resolves load-use hazards, EX-stage redirects, instruction- and data-memory busy stalls, and the halt drain sequence. It also keeps a saturating stall-cycle counter for performance debug.

Parameters:
DRAIN_CYCLES, 3, non-frozen cycles from halt leaving ID until it retires from WB; range 1..7.
CNT_W, 16, width of the stall-cycle counter.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-low
r1Num_id  in  3  ID-stage source register 1
r2Num_id  in  3  ID-stage source register 2
r1Used_id  in  1  ID instruction reads r1Num_id
r2Used_id  in  1  ID instruction reads r2Num_id
halt_id  in  1  halt instruction is in ID
regWriteNum_ex  in  3  destination register of the ID/EX instruction
regWriteEnable_ex  in  1  ID/EX instruction writes a register
memReadEnable_ex  in  1  ID/EX instruction is a load
redirect_ex  in  1  EX resolved a taken branch or jump; PC mux selects the target
imem_busy  in  1  instruction memory has not returned a fetch this cycle
dmem_busy  in  1  data memory has not completed the MEM access this cycle
stall_cnt_clr  in  1  synchronous clear of stall_cnt
pc_we  out  1  PC register load
ifid_we  out  1  IF/ID capture
ifid_flush  out  1  IF/ID captures a nop (overrides ifid_we data)
idex_we  out  1  ID/EX capture
idex_flush  out  1  ID/EX captures a nop, with all write and memory enables zero
exmem_we  out  1  EX/MEM capture
memwb_we  out  1  MEM/WB capture
halted  out  1  pipeline fully drained after halt
stall_cnt  out  CNT_W  saturating count of stall cycles

Behaviour:
- FSM states: RUN, DRAIN, HALTED. State, the drain counter (3 bits) and stall_cnt are the only flops. All enables and flushes are combinational from state and inputs.
- While rst=0 (asynchronous):
  - state=RUN, drain counter=0, stall_cnt=0, halted=0.
  - Outputs forced: all *_we=0, ifid_flush=1, idex_flush=1.
- Default (RUN, no event): all *_we=1, both flushes=0.
- Load-use hazard (lu) = memReadEnable_ex & regWriteEnable_ex & ((r1Used_id & r1Num_id==regWriteNum_ex) | (r2Used_id & r2Num_id==regWriteNum_ex)). Register 0 is not special.
- RUN priority, highest first:
  1. dmem_busy: all *_we=0, no flush (full freeze). Nothing else is evaluated.
  2. redirect_ex: pc_we=1, ifid_flush=1, idex_flush=1, exmem_we=1, memwb_we=1. Any lu or halt_id is squashed. Redirect with imem_busy still loads the PC.
  3. lu: pc_we=0, ifid_we=0, idex_flush=1, downstream stages advance. This gives exactly one bubble; the load leaves EX next cycle.
  4. halt_id: go to DRAIN with counter=DRAIN_CYCLES. This cycle pc_we=0, ifid_flush=1, and halt advances into ID/EX.
  5. imem_busy: pc_we=0, ifid_flush=1, downstream stages advance.
- DRAIN:
  - pc_we=0, ifid_flush=1, idex_flush=1.
  - exmem_we and memwb_we follow ~dmem_busy. redirect_ex, lu, halt_id and imem_busy are ignored.
  - The counter decrements on cycles with dmem_busy=0. When it decrements to 0, the next state is HALTED.
- HALTED: all *_we=0, halted=1, flushes=0. Only reset exits this state.
- stall_cnt:
  - Increments by 1 per cycle in RUN when dmem_busy, lu (no redirect), or imem_busy (no redirect/lu/halt) is selected.
  - Saturates at all-ones.
  - stall_cnt_clr takes priority over increment; the value is 0 next cycle.
  - Not counted in DRAIN or HALTED.
- Reset asserted mid-stall or mid-drain: immediate return to the reset state and outputs above.

Decomposition:
- Shared package pipe_ctrl_pkg: state encoding (RUN=2'd0, DRAIN=2'd1, HALTED=2'd2) and the default DRAIN_CYCLES constant.
- Sub-module hazard_detect: combinational lu comparator, so forwarding logic can reuse it.
- FSM, priority mux and counter live in the top module.

Test Plan:
- Load r3 in EX (memReadEnable_ex=1, regWriteEnable_ex=1, regWriteNum_ex=3), ID reads r1Num_id=3 with r1Used_id=1 -> for one cycle pc_we=0, ifid_we=0, idex_flush=1, exmem_we=1; stall_cnt 0->1. Same case with r1Used_id=0 -> no stall.
- redirect_ex=1 together with the lu case and imem_busy=1 -> pc_we=1, ifid_flush=1, idex_flush=1; stall_cnt unchanged.
- halt_id=1 in RUN, DRAIN_CYCLES=3, dmem_busy pulsed high for 2 cycles during drain -> halted rises exactly 5 cycles after entering DRAIN; all *_we=0 afterwards; halt_id with redirect_ex=1 -> remains in RUN.
- dmem_busy held 4 cycles with the lu case present -> all *_we=0, no flushes, stall_cnt +4; lu bubble then issued on the first cycle with dmem_busy=0.
- Force stall_cnt to 16'hFFFE, then apply 3 imem_busy cycles -> saturates at 16'hFFFF; stall_cnt_clr together with a stall -> 0.
- Assert rst=0 asynchronously mid-DRAIN -> outputs immediately reset values (enables 0, flushes 1, halted 0); after release the block is in RUN with default enables.
